// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
package mem_arb_pkg;

   localparam int unsigned AW_DEFAULT = 32;
   localparam int unsigned DW_DEFAULT = 32;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_e;

   typedef enum logic {
      OWN_IFU,
      OWN_LSU
   } owner_e;

endpackage

// File: rtl/mem_arbiter_arb2.sv
// Combinational two-way grant between IFU and LSU.
// MEM_ARB_RR_EN selects round-robin tie-break; otherwise LSU wins ties.
module arb2
   import mem_arb_pkg::*;
(
   input  logic   ifu_valid,
   input  logic   lsu_valid,
`ifdef MEM_ARB_RR_EN
   input  owner_e last_grant,
`endif
   output logic   grant_ifu,
   output logic   grant_lsu
);

   always_comb begin
      grant_ifu = 1'b0;
      grant_lsu = 1'b0;
      if (ifu_valid && lsu_valid) begin
`ifdef MEM_ARB_RR_EN
         grant_ifu = (last_grant == OWN_LSU);
         grant_lsu = (last_grant == OWN_IFU);
`else
         grant_lsu = 1'b1;
`endif
      end else begin
         grant_ifu = ifu_valid;
         grant_lsu = lsu_valid;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates IFU and LSU onto one memory port, one transaction in flight.
// Build option MEM_ARB_RR_EN: round-robin tie-break with a last-grant register.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned AW = AW_DEFAULT,
   parameter int unsigned DW = DW_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ifu_req_valid,
   output logic            ifu_req_ready,
   input  logic [AW-1:0]   ifu_addr,
   output logic            ifu_resp_valid,
   input  logic            ifu_resp_ready,
   output logic [DW-1:0]   ifu_rdata,
   input  logic            lsu_req_valid,
   output logic            lsu_req_ready,
   input  logic [AW-1:0]   lsu_addr,
   input  logic            lsu_wen,
   input  logic [DW-1:0]   lsu_wdata,
   input  logic [DW/8-1:0] lsu_wmask,
   output logic            lsu_resp_valid,
   input  logic            lsu_resp_ready,
   output logic [DW-1:0]   lsu_rdata,
   output logic            mem_req_valid,
   input  logic            mem_req_ready,
   output logic [AW-1:0]   mem_addr,
   output logic            mem_wen,
   output logic [DW-1:0]   mem_wdata,
   output logic [DW/8-1:0] mem_wmask,
   input  logic            mem_resp_valid,
   input  logic [DW-1:0]   mem_rdata
);

   state_e            state_q, state_d;
   owner_e            owner_q, owner_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic              wen_q, wen_d;
   logic [DW-1:0]     wdata_q, wdata_d;
   logic [DW/8-1:0]   wmask_q, wmask_d;
   logic [DW-1:0]     ifu_rdata_q, ifu_rdata_d;
   logic [DW-1:0]     lsu_rdata_q, lsu_rdata_d;
   logic              grant_ifu, grant_lsu;
`ifdef MEM_ARB_RR_EN
   owner_e            last_q, last_d;
`endif

   arb2 u_arb2 (
      .ifu_valid  (ifu_req_valid),
      .lsu_valid  (lsu_req_valid),
`ifdef MEM_ARB_RR_EN
      .last_grant (last_q),
`endif
      .grant_ifu  (grant_ifu),
      .grant_lsu  (grant_lsu)
   );

   // Outputs are forced quiet while rst is held, even before the reset edge.
   assign ifu_req_ready  = !rst && (state_q == IDLE) && grant_ifu;
   assign lsu_req_ready  = !rst && (state_q == IDLE) && grant_lsu;
   assign mem_req_valid  = !rst && (state_q == ISSUE);
   assign ifu_resp_valid = !rst && (state_q == RESP) && (owner_q == OWN_IFU);
   assign lsu_resp_valid = !rst && (state_q == RESP) && (owner_q == OWN_LSU);
   assign mem_addr       = rst ? '0 : addr_q;
   assign mem_wen        = !rst && wen_q;
   assign mem_wdata      = rst ? '0 : wdata_q;
   assign mem_wmask      = rst ? '0 : wmask_q;
   assign ifu_rdata      = rst ? '0 : ifu_rdata_q;
   assign lsu_rdata      = rst ? '0 : lsu_rdata_q;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      addr_d      = addr_q;
      wen_d       = wen_q;
      wdata_d     = wdata_q;
      wmask_d     = wmask_q;
      ifu_rdata_d = ifu_rdata_q;
      lsu_rdata_d = lsu_rdata_q;
`ifdef MEM_ARB_RR_EN
      last_d      = last_q;
`endif
      case (state_q)
         IDLE: begin
            if (lsu_req_ready) begin
               owner_d = OWN_LSU;
               addr_d  = lsu_addr;
               wen_d   = lsu_wen;
               wdata_d = lsu_wdata;
               wmask_d = lsu_wmask;
               state_d = ISSUE;
            end else if (ifu_req_ready) begin
               owner_d = OWN_IFU;
               addr_d  = ifu_addr;
               wen_d   = 1'b0;
               wdata_d = '0;
               wmask_d = '0;
               state_d = ISSUE;
            end
`ifdef MEM_ARB_RR_EN
            if (lsu_req_ready || ifu_req_ready) last_d = owner_d;
`endif
         end
         ISSUE: begin
            if (mem_req_ready) state_d = WAIT;
         end
         WAIT: begin
            if (mem_resp_valid) begin
               if (owner_q == OWN_LSU) lsu_rdata_d = mem_rdata;
               else                    ifu_rdata_d = mem_rdata;
               state_d = RESP;
            end
         end
         RESP: begin
            if ((owner_q == OWN_IFU && ifu_resp_ready) ||
                (owner_q == OWN_LSU && lsu_resp_ready)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_q     <= OWN_IFU;
         addr_q      <= '0;
         wen_q       <= 1'b0;
         wdata_q     <= '0;
         wmask_q     <= '0;
         ifu_rdata_q <= '0;
         lsu_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
         last_q      <= OWN_LSU;
`endif
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         addr_q      <= addr_d;
         wen_q       <= wen_d;
         wdata_q     <= wdata_d;
         wmask_q     <= wmask_d;
         ifu_rdata_q <= ifu_rdata_d;
         lsu_rdata_q <= lsu_rdata_d;
`ifdef MEM_ARB_RR_EN
         last_q      <= last_d;
`endif
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// transactions against a transaction-level model (honours MEM_ARB_RR_EN).
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
   logic [31:0] ifu_addr, ifu_rdata;
   logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
   logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
   logic [3:0]  lsu_wmask;
   logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wmask;

   int          checks = 0;
   int          failures = 0;

   // Model: who was granted last (1 = LSU) and each port's last returned data.
   bit          m_last_lsu;
   logic [31:0] m_ifu_rdata, m_lsu_rdata;

   always #5 clk = ~clk;

   mem_arbiter #(.AW(32), .DW(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .ifu_req_valid  (ifu_req_valid),
      .ifu_req_ready  (ifu_req_ready),
      .ifu_addr       (ifu_addr),
      .ifu_resp_valid (ifu_resp_valid),
      .ifu_resp_ready (ifu_resp_ready),
      .ifu_rdata      (ifu_rdata),
      .lsu_req_valid  (lsu_req_valid),
      .lsu_req_ready  (lsu_req_ready),
      .lsu_addr       (lsu_addr),
      .lsu_wen        (lsu_wen),
      .lsu_wdata      (lsu_wdata),
      .lsu_wmask      (lsu_wmask),
      .lsu_resp_valid (lsu_resp_valid),
      .lsu_resp_ready (lsu_resp_ready),
      .lsu_rdata      (lsu_rdata),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_addr       (mem_addr),
      .mem_wen        (mem_wen),
      .mem_wdata      (mem_wdata),
      .mem_wmask      (mem_wmask),
      .mem_resp_valid (mem_resp_valid),
      .mem_rdata      (mem_rdata)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit model_pick_lsu(input bit iv, input bit lv);
      if (iv && lv) begin
`ifdef MEM_ARB_RR_EN
         return !m_last_lsu;
`else
         return 1'b1;
`endif
      end
      return lv;
   endfunction

   task automatic chk_rdata(input string tag);
      chk({tag, "_ifu_rdata"}, ifu_rdata, m_ifu_rdata);
      chk({tag, "_lsu_rdata"}, lsu_rdata, m_lsu_rdata);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_ifu_rvalid"}, ifu_resp_valid, 0);
      chk({tag, "_lsu_rvalid"}, lsu_resp_valid, 0);
      chk({tag, "_mreq_valid"}, mem_req_valid, 0);
   endtask

   // One complete transaction; request valids stay high until it retires.
   task automatic txn(input bit iv, input bit lv, input logic [31:0] ia, input logic [31:0] la,
                      input bit lw, input logic [31:0] lwd, input logic [3:0] lwm,
                      input int rdy_dly, input int rsp_dly, input int hold_dly,
                      input logic [31:0] rdata, output bit got_lsu);
      bit          pick_lsu;
      logic [31:0] e_addr, e_wdata;
      bit          e_wen;
      logic [3:0]  e_wmask;
      ifu_req_valid = iv; ifu_addr = ia;
      lsu_req_valid = lv; lsu_addr = la; lsu_wen = lw; lsu_wdata = lwd; lsu_wmask = lwm;
      #1;
      pick_lsu = model_pick_lsu(iv, lv);
      chk("idle_ifu_ready", ifu_req_ready, iv && !pick_lsu);
      chk("idle_lsu_ready", lsu_req_ready, pick_lsu);
      got_lsu    = lsu_req_ready;
      m_last_lsu = pick_lsu;
      e_addr  = pick_lsu ? la : ia;
      e_wen   = pick_lsu ? lw : 1'b0;
      e_wdata = pick_lsu ? lwd : 32'h0;
      e_wmask = pick_lsu ? lwm : 4'h0;
      tick();
      for (int i = 0; i <= rdy_dly; i++) begin
         chk("issue_valid", mem_req_valid, 1);
         chk("issue_addr", mem_addr, e_addr);
         chk("issue_wen", mem_wen, e_wen);
         chk("issue_wdata", mem_wdata, e_wdata);
         chk("issue_wmask", mem_wmask, e_wmask);
         chk("issue_ready", {ifu_req_ready, lsu_req_ready}, 0);
         chk("issue_rvalid", {ifu_resp_valid, lsu_resp_valid}, 0);
         chk_rdata("issue");
         mem_req_ready  = (i == rdy_dly);
         mem_resp_valid = 1'($urandom_range(0, 1));
         mem_rdata      = $urandom;
         tick();
      end
      mem_req_ready = 1'b0;
      for (int i = 0; i <= rsp_dly; i++) begin
         chk_quiet("wait");
         chk("wait_ready", {ifu_req_ready, lsu_req_ready}, 0);
         chk_rdata("wait");
         mem_resp_valid = (i == rsp_dly);
         mem_rdata      = (i == rsp_dly) ? rdata : $urandom;
         tick();
      end
      mem_resp_valid = 1'b0;
      if (pick_lsu) m_lsu_rdata = rdata;
      else          m_ifu_rdata = rdata;
      for (int i = 0; i <= hold_dly; i++) begin
         chk("resp_ifu_valid", ifu_resp_valid, !pick_lsu);
         chk("resp_lsu_valid", lsu_resp_valid, pick_lsu);
         chk_rdata("resp");
         chk("resp_mreq_valid", mem_req_valid, 0);
         chk("resp_ready", {ifu_req_ready, lsu_req_ready}, 0);
         ifu_resp_ready = (i == hold_dly) ? 1'b1 : (pick_lsu ? 1'($urandom_range(0, 1)) : 1'b0);
         lsu_resp_ready = (i == hold_dly) ? 1'b1 : (pick_lsu ? 1'b0 : 1'($urandom_range(0, 1)));
         mem_resp_valid = 1'($urandom_range(0, 1));
         mem_rdata      = $urandom;
         tick();
      end
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
      ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
      mem_resp_valid = 1'b0;
      #1;
      chk_quiet("retire");
      chk_rdata("retire");
   endtask

   initial begin
      bit          got;
      bit          exp_lsu;
      bit          iv, lv;
      rst = 1'b1;
      ifu_req_valid = 0; ifu_addr = 0; ifu_resp_ready = 0;
      lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0; lsu_resp_ready = 0;
      mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
      m_last_lsu = 1'b1; m_ifu_rdata = 0; m_lsu_rdata = 0;
      tick();
      tick();

      // Reset state, with requests asserted.
      ifu_req_valid = 1; lsu_req_valid = 1;
      #1;
      chk("rst_ready", {ifu_req_ready, lsu_req_ready}, 0);
      chk_quiet("rst");
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wen", mem_wen, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_wmask", mem_wmask, 0);
      chk_rdata("rst");
      ifu_req_valid = 0; lsu_req_valid = 0;
      rst = 1'b0;
      tick();

      // IFU fetch at minimum latency.
      txn(1, 0, 32'h8000_0000, 32'h0, 0, 32'h0, 4'h0, 0, 0, 0, 32'h0000_0413, got);
      chk("t_ifu_owner", got, 0);

      // LSU write held off by 3 cycles of mem_req_ready=0.
      txn(0, 1, 32'h0, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'hF, 3, 0, 0, $urandom, got);
      chk("t_lsu_owner", got, 1);

      // IFU response held 5 cycles by resp_ready=0.
      txn(1, 0, 32'h8000_0004, 32'h0, 0, 32'h0, 4'h0, 0, 1, 5, $urandom, got);

      // Requester withdraws before the edge: no grant.
      ifu_req_valid = 1; ifu_addr = 32'h1234_0000;
      #1;
      chk("drop_ready_hi", ifu_req_ready, 1);
      ifu_req_valid = 0;
      #1;
      chk("drop_ready_lo", ifu_req_ready, 0);
      tick();
      chk("drop_no_issue", mem_req_valid, 0);
      tick();
      chk("drop_no_issue2", mem_req_valid, 0);

      // Stray memory response while idle.
      mem_resp_valid = 1; mem_rdata = 32'h1234_5678;
      tick();
      mem_resp_valid = 0;
      chk_quiet("idle_stray");
      chk_rdata("idle_stray");

      // Back-to-back ties from a fresh reset.
      rst = 1; tick(); rst = 0;
      m_last_lsu = 1'b1; m_ifu_rdata = 0; m_lsu_rdata = 0;
      for (int k = 0; k < 4; k++) begin
         txn(1, 1, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom),
             0, 0, 0, $urandom, got);
`ifdef MEM_ARB_RR_EN
         exp_lsu = (k % 2 == 1);
`else
         exp_lsu = 1'b1;
`endif
         chk($sformatf("tie_grant_%0d", k), got, exp_lsu);
      end

      // Reset while waiting on memory, then a late response.
      ifu_req_valid = 1; ifu_addr = 32'h8000_0100;
      tick();
      ifu_req_valid = 0; mem_req_ready = 1;
      tick();
      mem_req_ready = 0;
      chk("midrst_in_wait", mem_req_valid, 0);
      rst = 1; lsu_req_valid = 1;
      #1;
      chk("midrst_ready", {ifu_req_ready, lsu_req_ready}, 0);
      chk_quiet("midrst_pre");
      mem_resp_valid = 1; mem_rdata = 32'hBAD0_BAD0;
      tick();
      m_last_lsu = 1'b1; m_ifu_rdata = 0; m_lsu_rdata = 0;
      chk_quiet("midrst_post");
      chk_rdata("midrst_post");
      rst = 0; lsu_req_valid = 0;
      tick();
      mem_resp_valid = 0;
      chk_quiet("midrst_late");
      chk_rdata("midrst_late");
      tick();
      chk_quiet("midrst_idle");
      txn(1, 1, 32'h8000_0200, 32'h8000_0300, 0, 32'h0, 4'h0, 1, 1, 1, 32'hCAFE_F00D, got);
`ifdef MEM_ARB_RR_EN
      chk("midrst_first_tie", got, 0);
`else
      chk("midrst_first_tie", got, 1);
`endif

      // Randomized traffic.
      for (int n = 0; n < 40; n++) begin
         iv = 1'($urandom_range(0, 1));
         lv = 1'($urandom_range(0, 1));
         if (!iv && !lv) iv = 1'b1;
         txn(iv, lv, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom, got);
         if ($urandom_range(0, 3) == 0) begin
            mem_resp_valid = 1; mem_rdata = $urandom;
            tick();
            mem_resp_valid = 0;
            chk_rdata("rand_idle");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, 32, address width.
REQ-002 Parameter DW, 32, data width; the write mask is DW/8 bits wide.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 ifu_req_valid in 1 / ifu_req_ready out 1 / ifu_addr in AW  instruction-fetch read request.
REQ-006 ifu_resp_valid out 1 / ifu_resp_ready in 1 / ifu_rdata out DW  instruction-fetch response.
REQ-007 lsu_req_valid in 1 / lsu_req_ready out 1 / lsu_addr in AW / lsu_wen in 1 / lsu_wdata in DW / lsu_wmask in DW/8  load-store request.
REQ-008 lsu_resp_valid out 1 / lsu_resp_ready in 1 / lsu_rdata out DW  load-store response; writes also receive a response.
REQ-009 mem_req_valid out 1 / mem_req_ready in 1 / mem_addr out AW / mem_wen out 1 / mem_wdata out DW / mem_wmask out DW/8  shared memory request port.
REQ-010 mem_resp_valid in 1 / mem_rdata in DW  shared memory response; has no backpressure.

Function
REQ-011 The block SHALL use FSM states IDLE, ISSUE, WAIT and RESP, with one transaction outstanding at most.
REQ-012 IDLE: arbitrate among the asserted req_valids and raise req_ready combinationally for the winner only. On accept, latch the owner, addr, wen, wdata and wmask, then go to ISSUE. With no requester, stay in IDLE.
REQ-013 IFU requests SHALL drive mem_wen=0, mem_wmask=0 and mem_wdata=0.
REQ-014 ISSUE: hold mem_req_valid=1 with the latched fields stable. Go to WAIT on mem_req_ready.
REQ-015 WAIT: on mem_resp_valid, capture mem_rdata into the owner's rdata register and go to RESP. mem_resp_valid SHALL be ignored in every other state.
REQ-016 RESP: hold owner resp_valid=1 and rdata stable until resp_ready, then go to IDLE. No new request is accepted in the same cycle.
REQ-017 Minimum latency: accept at cycle N, mem_req_valid at N+1, response at N+3 when the memory is ready and responds in consecutive cycles.
REQ-018 Both req_ready outputs SHALL be 0 outside IDLE. The non-owner's resp_valid SHALL always be 0.
REQ-019 ifu_rdata and lsu_rdata SHALL hold their last captured value between transactions.
REQ-020 Simultaneous IFU and LSU valid in IDLE: grant per REQ-026/REQ-027.
REQ-021 A requester dropping req_valid in IDLE before accept SHALL not be granted.

Reset
REQ-022 While rst=1, the block SHALL drive state=IDLE and all valid/ready outputs to 0.
REQ-023 While rst=1, the block SHALL drive mem_addr, mem_wdata, mem_wmask, mem_wen, ifu_rdata and lsu_rdata to 0.
REQ-024 On reset, the last-grant register SHALL be set to LSU, so the IFU wins the first tie.
REQ-025 Reset mid-transaction SHALL abandon the transaction: no resp_valid is issued, and a late mem_resp_valid is ignored.

Configuration
REQ-026 With MEM_ARB_RR_EN defined, ties SHALL be resolved round-robin. The grant goes to the requester not granted last, and last-grant updates on every accept.
REQ-027 Without MEM_ARB_RR_EN, ties SHALL be resolved by fixed priority, LSU over IFU. No last-grant register is instantiated.

Structure
REQ-028 Package mem_arb_pkg SHALL hold the state enum (IDLE/ISSUE/WAIT/RESP), the owner enum (OWN_IFU/OWN_LSU) and the default AW/DW constants.
REQ-029 Sub-module arb2 SHALL compute the two-way grant from the two valids and last-grant. It is combinational, and the round-robin/fixed choice is selected by MEM_ARB_RR_EN.

Verification
REQ-030 IFU alone, ifu_addr=0x80000000, memory returns 0x00000413 one cycle after accept -> ifu_resp_valid at accept+3 with ifu_rdata=0x00000413; lsu_resp_valid stays 0.
REQ-031 LSU write addr=0x80001000, wdata=0xDEADBEEF, wmask=0xF -> mem_wen=1 with those fields stable through 3 cycles of mem_req_ready=0; lsu_resp_valid follows.
REQ-032 Both valid every cycle for 4 transactions -> with MEM_ARB_RR_EN, grants are IFU,LSU,IFU,LSU; without it, LSU,LSU,LSU,LSU.
REQ-033 ifu_resp_ready=0 for 5 cycles in RESP -> ifu_resp_valid and ifu_rdata stay constant, both req_ready stay 0, and no mem_req_valid is issued.
REQ-034 rst asserted during WAIT, then mem_resp_valid pulsed -> no resp_valid on either port; state is IDLE and the next request completes normally.
REQ-035 mem_resp_valid pulsed while in IDLE -> ignored; ifu_rdata and lsu_rdata are unchanged.
